// File: rtl/alu_cmd_unit.sv
// alu_cmd_unit: command-driven sequential ALU with valid/ready command intake,
// registered output strobe and one-bit-per-cycle multi-bit shifts.
module alu_cmd_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [15:0]      flags
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  // Command codes
  localparam logic [3:0] CMD_NOP     = 4'h0;
  localparam logic [3:0] CMD_LATCHA  = 4'h1;
  localparam logic [3:0] CMD_LATCHB  = 4'h2;
  localparam logic [3:0] CMD_LATCHF  = 4'h3;
  localparam logic [3:0] CMD_LATCHOP = 4'h4;
  localparam logic [3:0] CMD_OUTPUTY = 4'h5;
  localparam logic [3:0] CMD_OUTPUTF = 4'h6;
  localparam logic [3:0] CMD_COMPUTE = 4'h7;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADC  = 4'h1;
  localparam logic [3:0] OP_SBC  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_DEC  = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_LSH  = 4'hB;
  localparam logic [3:0] OP_RSH  = 4'hC;

  // Flag bit positions
  localparam int unsigned FLAG_C   = 0;
  localparam int unsigned FLAG_Z   = 1;
  localparam int unsigned FLAG_EQ  = 2;
  localparam int unsigned FLAG_GT  = 3;
  localparam int unsigned FLAG_LT  = 4;
  localparam int unsigned FLAG_ERR = 15;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [3:0]       op_q, op_d;
  logic [15:0]      f_q, f_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [WIDTH-1:0] arith_b;
  logic             arith_cin;
  logic [WIDTH:0]   arith_sum;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_wr;
  logic [WIDTH-1:0] shift_y;
  logic             shift_out;
  logic [SW-1:0]    shift_n;

  assign shift_n = b_q[SW-1:0];

  // Shared WIDTH+1-bit adder for ADD/ADC/SBC/CMP; B is inverted for subtract forms
  always_comb begin
    arith_b   = b_q;
    arith_cin = f_q[FLAG_C];
    case (op_q)
      OP_ADD:  arith_cin = 1'b0;
      OP_SBC:  arith_b   = ~b_q;
      OP_CMP: begin
        arith_b   = ~b_q;
        arith_cin = 1'b1;
      end
      default: ;
    endcase
    arith_sum = {1'b0, a_q} + {1'b0, arith_b} + (WIDTH+1)'(arith_cin);
    inc_sum   = {1'b0, a_q} + (WIDTH+1)'(1);
  end

  // Single-cycle result, carry and "writes Y" indication per opcode
  always_comb begin
    alu_y  = y_q;
    alu_c  = 1'b0;
    alu_wr = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC, OP_SBC: begin
        alu_y  = arith_sum[WIDTH-1:0];
        alu_c  = arith_sum[WIDTH];
        alu_wr = 1'b1;
      end
      OP_INC: begin
        alu_y  = inc_sum[WIDTH-1:0];
        alu_c  = inc_sum[WIDTH];
        alu_wr = 1'b1;
      end
      OP_DEC: begin
        alu_y  = a_q - WIDTH'(1);
        alu_c  = (a_q != '0);
        alu_wr = 1'b1;
      end
      OP_NAND: begin
        alu_y  = ~(a_q & b_q);
        alu_wr = 1'b1;
      end
      OP_AND: begin
        alu_y  = a_q & b_q;
        alu_wr = 1'b1;
      end
      OP_OR: begin
        alu_y  = a_q | b_q;
        alu_wr = 1'b1;
      end
      OP_NOR: begin
        alu_y  = ~(a_q | b_q);
        alu_wr = 1'b1;
      end
      OP_XOR: begin
        alu_y  = a_q ^ b_q;
        alu_wr = 1'b1;
      end
      default: ;
    endcase
  end

  // One-bit shift step of Y; direction follows the latched opcode
  always_comb begin
    if (op_q == OP_RSH) begin
      shift_y   = {1'b0, y_q[WIDTH-1:1]};
      shift_out = y_q[0];
    end else begin
      shift_y   = {y_q[WIDTH-2:0], 1'b0};
      shift_out = y_q[WIDTH-1];
    end
  end

  // Next-state: command decode in IDLE, shift sequencing in SHIFT
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    y_d         = y_q;
    op_d        = op_q;
    f_d         = f_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_NOP:     ;
            CMD_LATCHA:  a_d  = data_in;
            CMD_LATCHB:  b_d  = data_in;
            CMD_LATCHF:  f_d  = data_in[15:0];
            CMD_LATCHOP: op_d = data_in[3:0];
            CMD_OUTPUTY: begin
              out_valid_d = 1'b1;
              out_data_d  = y_q;
            end
            CMD_OUTPUTF: begin
              out_valid_d = 1'b1;
              out_data_d  = WIDTH'(f_q);
            end
            CMD_COMPUTE: begin
              if (alu_wr) begin
                y_d         = alu_y;
                f_d[FLAG_C] = alu_c;
                f_d[FLAG_Z] = (alu_y == '0);
              end else if (op_q == OP_CMP) begin
                f_d[FLAG_C]  = arith_sum[WIDTH];
                f_d[FLAG_EQ] = (a_q == b_q);
                f_d[FLAG_GT] = (a_q > b_q);
                f_d[FLAG_LT] = (a_q < b_q);
              end else if ((op_q == OP_LSH) || (op_q == OP_RSH)) begin
                y_d = a_q;
                if (shift_n == '0) begin
                  f_d[FLAG_C] = 1'b0;
                  f_d[FLAG_Z] = (a_q == '0);
                end else begin
                  cnt_d   = CW'(shift_n);
                  state_d = ST_SHIFT;
                end
              end else begin
                f_d[FLAG_ERR] = 1'b1;
              end
            end
            default: f_d[FLAG_ERR] = 1'b1;
          endcase
        end
      end
      ST_SHIFT: begin
        y_d         = shift_y;
        f_d[FLAG_C] = shift_out;
        cnt_d       = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          f_d[FLAG_Z] = (shift_y == '0);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      y_q         <= '0;
      op_q        <= '0;
      f_q         <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      y_q         <= y_d;
      op_q        <= op_d;
      f_q         <= f_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SHIFT);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign flags     = f_q;

endmodule

// File: tb/tb_alu_cmd_unit.sv
// Directed bench for alu_cmd_unit at WIDTH=16.
module tb_alu_cmd_unit;

  localparam int unsigned WIDTH = 16;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] LA  = 4'h1;
  localparam logic [3:0] LB  = 4'h2;
  localparam logic [3:0] LF  = 4'h3;
  localparam logic [3:0] LOP = 4'h4;
  localparam logic [3:0] OY  = 4'h5;
  localparam logic [3:0] OF  = 4'h6;
  localparam logic [3:0] CMP = 4'h7;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic [15:0]      flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  cmd;
    logic [15:0] data;
    logic        exp_valid;
    logic [15:0] exp_out;
    logic [15:0] exp_flags;
  } vec_t;

  vec_t vecs[$];

  alu_cmd_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] c, input logic [15:0] d, input logic v,
                              input logic [15:0] o, input logic [15:0] f);
    vecs.push_back('{c, d, v, o, f});
  endfunction

  // Present one command for one edge (unit assumed ready), sample 1 time unit later
  task automatic issue(input logic [3:0] c, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd       = c;
    data_in   = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = NOP;
  endtask

  // COMPUTE a shift, hold OUTPUTY until accepted, then check latency and result
  task automatic do_shift(input string name, input int n, input logic [15:0] exp_y,
                          input logic [15:0] exp_f);
    int cnt;
    issue(CMP, 16'h0000);
    chk({name, " ready_after_accept"}, cmd_ready, (n == 0));
    chk({name, " busy_after_accept"}, busy, (n != 0));
    cmd_valid = 1'b1;
    cmd       = OY;
    cnt       = 0;
    while (!cmd_ready && cnt < 64) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({name, " busy_cycles"}, cnt, n);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = NOP;
    chk({name, " out_valid"}, out_valid, 1'b1);
    chk({name, " y"}, out_data, exp_y);
    chk({name, " flags"}, flags, exp_f);
    chk({name, " busy_done"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // cmd, data, exp out_valid, exp out_data (held), exp flags
    add(LA,  16'hFFFF, 0, 16'h0000, 16'h0000);
    add(LB,  16'h0001, 0, 16'h0000, 16'h0000);
    add(LOP, 16'h0000, 0, 16'h0000, 16'h0000);
    add(CMP, 16'h0000, 0, 16'h0000, 16'h0003);  // ADD wraps: C=1 Z=1
    add(OY,  16'h0000, 1, 16'h0000, 16'h0003);
    add(NOP, 16'h0000, 0, 16'h0000, 16'h0003);  // strobe lasts one cycle
    add(LA,  16'h0003, 0, 16'h0000, 16'h0003);
    add(LB,  16'h0005, 0, 16'h0000, 16'h0003);
    add(LOP, 16'h0002, 0, 16'h0000, 16'h0003);
    add(LF,  16'h0001, 0, 16'h0000, 16'h0001);
    add(CMP, 16'h0000, 0, 16'h0000, 16'h0000);  // SBC -> FFFE, C=0 Z=0
    add(OY,  16'h0000, 1, 16'hFFFE, 16'h0000);
    add(OF,  16'h0000, 1, 16'h0000, 16'h0000);
    add(LA,  16'h0005, 0, 16'h0000, 16'h0000);
    add(LB,  16'h0009, 0, 16'h0000, 16'h0000);
    add(LOP, 16'h0003, 0, 16'h0000, 16'h0000);
    add(CMP, 16'h0000, 0, 16'h0000, 16'h0010);  // CMP 5<9: LT
    add(OY,  16'h0000, 1, 16'hFFFE, 16'h0010);  // Y untouched by CMP
    add(LA,  16'h0009, 0, 16'hFFFE, 16'h0010);
    add(CMP, 16'h0000, 0, 16'hFFFE, 16'h0005);  // CMP 9==9: EQ, C=1
    add(OF,  16'h0000, 1, 16'h0005, 16'h0005);
    add(LF,  16'h0001, 0, 16'h0005, 16'h0001);
    add(LOP, 16'h0001, 0, 16'h0005, 16'h0001);
    add(LA,  16'h0010, 0, 16'h0005, 16'h0001);
    add(LB,  16'h0020, 0, 16'h0005, 16'h0001);
    add(CMP, 16'h0000, 0, 16'h0005, 16'h0000);  // ADC 0x10+0x20+1
    add(OY,  16'h0000, 1, 16'h0031, 16'h0000);
    add(LOP, 16'h0004, 0, 16'h0031, 16'h0000);
    add(LA,  16'hFFFF, 0, 16'h0031, 16'h0000);
    add(CMP, 16'h0000, 0, 16'h0031, 16'h0003);  // INC wraps
    add(OY,  16'h0000, 1, 16'h0000, 16'h0003);
    add(LOP, 16'h0005, 0, 16'h0000, 16'h0003);
    add(LA,  16'h0000, 0, 16'h0000, 16'h0003);
    add(CMP, 16'h0000, 0, 16'h0000, 16'h0000);  // DEC 0 -> FFFF, C=0
    add(OY,  16'h0000, 1, 16'hFFFF, 16'h0000);
    add(LOP, 16'h000A, 0, 16'hFFFF, 16'h0000);
    add(LA,  16'h00FF, 0, 16'hFFFF, 16'h0000);
    add(LB,  16'h0F0F, 0, 16'hFFFF, 16'h0000);
    add(CMP, 16'h0000, 0, 16'hFFFF, 16'h0000);  // XOR
    add(OY,  16'h0000, 1, 16'h0FF0, 16'h0000);
    add(LOP, 16'h0006, 0, 16'h0FF0, 16'h0000);
    add(LA,  16'hFFFF, 0, 16'h0FF0, 16'h0000);
    add(LB,  16'hFFFF, 0, 16'h0FF0, 16'h0000);
    add(CMP, 16'h0000, 0, 16'h0FF0, 16'h0002);  // NAND -> 0, Z=1
    add(OY,  16'h0000, 1, 16'h0000, 16'h0002);
    add(LOP, 16'h000C, 0, 16'h0000, 16'h0002);
    add(LA,  16'h1234, 0, 16'h0000, 16'h0002);
    add(LB,  16'h0010, 0, 16'h0000, 16'h0002);
    add(CMP, 16'h0000, 0, 16'h0000, 16'h0000);  // RSH n=0 completes at once
    add(OY,  16'h0000, 1, 16'h1234, 16'h0000);
    add(LF,  16'h0000, 0, 16'h1234, 16'h0000);
    add(LOP, 16'h000E, 0, 16'h1234, 16'h0000);
    add(CMP, 16'h0000, 0, 16'h1234, 16'h8000);  // illegal opcode sets ERR
    add(OY,  16'h0000, 1, 16'h1234, 16'h8000);
    add(4'h9, 16'hABCD, 0, 16'h1234, 16'h8000); // illegal command, ERR sticky
    add(4'hF, 16'hABCD, 0, 16'h1234, 16'h8000);
    add(LF,  16'h5A40, 0, 16'h1234, 16'h5A40);
    add(OF,  16'h0000, 1, 16'h5A40, 16'h5A40);
    add(LF,  16'h0000, 0, 16'h5A40, 16'h0000);

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd       = NOP;
    data_in   = '0;
    #1;
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset flags", flags, 16'h0000);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset out_data", out_data, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].cmd, vecs[i].data);
      chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_out);
      chk($sformatf("vec%0d flags", i), flags, vecs[i].exp_flags);
      chk($sformatf("vec%0d cmd_ready", i), cmd_ready, 1'b1);
    end

    // Multi-cycle shifts
    issue(LOP, 16'h000B);
    issue(LA,  16'h8001);
    issue(LB,  16'h0003);
    do_shift("lsh3", 3, 16'h0008, 16'h0000);
    issue(LB,  16'h0011);
    do_shift("lsh1", 1, 16'h0002, 16'h0001);
    issue(LOP, 16'h000C);
    issue(LA,  16'h0006);
    issue(LB,  16'h0002);
    do_shift("rsh2", 2, 16'h0001, 16'h0001);
    issue(LA,  16'h0001);
    issue(LB,  16'h0001);
    do_shift("rsh1_zero", 1, 16'h0000, 16'h0003);
    issue(LOP, 16'h000B);
    issue(LB,  16'h000F);
    do_shift("lsh15", 15, 16'h8000, 16'h0000);

    // Reset in the middle of a long shift
    issue(LF,  16'h0030);
    issue(CMP, 16'h0000);
    repeat (5) begin
      @(posedge clk);
    end
    #1;
    chk("midshift busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort cmd_ready", cmd_ready, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort flags", flags, 16'h0000);
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort out_data", out_data, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset out_valid", out_valid, 1'b0);
    issue(OY, 16'h0000);
    chk("post_reset OY valid", out_valid, 1'b1);
    chk("post_reset OY data", out_data, 16'h0000);
    issue(CMP, 16'h0000);
    chk("post_reset add flags", flags, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_unit.md
# alu_cmd_unit

Command-driven, width-parametrised sequential ALU for the Argon datapath. It is the next generation of the bus-commanded ALU and keeps the same 4-bit command and opcode encodings. It adds a valid/ready command handshake, a registered output strobe, and multi-bit shifts executed one bit per cycle. It sits between the control sequencer (command/data source) and the register-file write-back bus.

## Interface
- WIDTH, 16, data width; legal values 16, 32, 64. The shift count field is SW = log2(WIDTH) bits.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  unit can accept a command; a command is accepted when cmd_valid && cmd_ready.
- cmd  in  4  command code: 0 NOP, 1 LATCHA, 2 LATCHB, 3 LATCHF, 4 LATCHOP, 5 OUTPUTY, 6 OUTPUTF, 7 COMPUTE.
- data_in  in  WIDTH  operand for latch commands.
- out_valid  out  1  one-cycle strobe; out_data is valid.
- out_data  out  WIDTH  result of the last OUTPUTY/OUTPUTF; held between strobes.
- busy  out  1  a multi-cycle shift is in progress.
- flags  out  16  live view of flag register F.

## Operation
- Internal registers: A, B, Y (WIDTH); OP (4); F (16); shift counter (SW+1 bits).
- Flag bits: C=0, Z=1, EQ=2, GT=3, LT=4, ERR=15. All other bits are written only by LATCHF.
- States: IDLE and SHIFT. cmd_ready = (state==IDLE). busy = (state==SHIFT).
- LATCHA/LATCHB: A/B <= data_in.
- LATCHF: F <= data_in[15:0]. This is the only way to clear ERR.
- LATCHOP: OP <= data_in[3:0].
- OUTPUTY: out_data <= Y, out_valid pulses.
- OUTPUTF: out_data <= zero-extended F, out_valid pulses.
- Commands 8–F: no register change except ERR <= 1.
- COMPUTE uses WIDTH+1-bit arithmetic. C is the carry out of bit WIDTH-1. Z = (new Y == 0) for every op that writes Y.
  - ADD (0): Y = A+B.
  - ADC (1): Y = A+B+C.
  - SBC (2): Y = A+~B+C.
  - CMP (3): Y unchanged; C = carry of A+~B+1; EQ = (A==B); GT = (A>B); LT = (A<B), all unsigned; Z unchanged.
  - INC (4): Y = A+1, C = carry out.
  - DEC (5): Y = A-1, C = (A!=0).
  - NAND, AND, OR, NOR, XOR (6–A): bitwise on A and B; C <= 0.
  - LSH (B) / RSH (C): logical shift of A by n = B[SW-1:0]. C = last bit shifted out. If n=0, C <= 0.
  - Opcodes D–F: ERR <= 1; Y and all other flags unchanged.
- EQ, GT and LT are written only by CMP. ERR is sticky.
- Shift sequencing:
  - On acceptance: Y <= A.
  - If n>0: counter <= n, enter SHIFT. Each SHIFT cycle shifts Y by one bit, C <= bit shifted out, counter decrements.
  - At counter==1: update Z from the final Y and return to IDLE.
  - If n=0: complete in the acceptance cycle; stay in IDLE.

## Timing
- Reset values: A=B=Y=0, OP=0, F=0, out_data=0, out_valid=0, busy=0, state=IDLE, cmd_ready=1. All take effect asynchronously.
- A command accepted at edge T has its register effects visible after T+1. out_valid is high exactly in cycle T+1.
- Non-shift COMPUTE: 1-cycle latency; cmd_ready stays high, so back-to-back commands are allowed.
- Shift with n>0: cmd_ready is low for n cycles after acceptance; the result is valid and cmd_ready returns high after edge T+n.
- Back-to-back dependencies:
  - LATCHx at T followed by COMPUTE at T+1 uses the new value.
  - COMPUTE at T followed by OUTPUTY at T+1 returns the new Y.
  - LATCHF at T followed by ADC at T+1 uses the new C.
- cmd_valid while cmd_ready=0: ignored. The source must hold the command until it is accepted.
- Reset asserted mid-shift: abort immediately, all state returns to reset values, and no out_valid is produced.

## Test plan
- WIDTH=16: LATCHA 0xFFFF, LATCHB 0x0001, LATCHOP 0, COMPUTE, OUTPUTY -> out_data=0x0000 with out_valid for one cycle; flags C=1, Z=1.
- SBC: A=0x0003, B=0x0005, F=0x0001 -> Y=0xFFFE, C=0, Z=0.
- CMP: A=5, B=9 -> LT=1, GT=0, EQ=0, Y unchanged from the previous value. Then A=9 -> EQ=1.
- LSH: A=0x8001, B=0x0003 -> cmd_ready low for 3 cycles, Y=0x0008, C=0. Then B=0x0011 -> n=1, Y=0x0002, C=1, 1-cycle busy.
- LATCHOP 0xE, COMPUTE -> F=0x8000 with Y unchanged. Then cmd 0x9 -> ERR stays 1. Then LATCHF 0x0000 -> flags=0.
- Shift A=0x0001, B=0x000F; assert reset after 5 SHIFT cycles -> cmd_ready=1, busy=0, flags=0, out_valid=0 in the same cycle. A subsequent OUTPUTY returns 0x0000.
